// File: rtl/viterbi_pkg.sv
// Shared types, code constants and branch helpers for the K=3, rate-1/2 (7,5) Viterbi decoder.
package viterbi_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] sym_t;

    localparam logic [2:0]  G0         = 3'b111;
    localparam logic [2:0]  G1         = 3'b101;
    localparam int unsigned NUM_STATES = 4;
    localparam int unsigned PM_INIT    = 4;

    // Encoder register is {u, s1, s0}; each output is the parity of the tapped bits.
    function automatic sym_t expected_sym(input state_t s, input logic u);
        logic [2:0] r;
        r = {u, s};
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] branch_metric(input sym_t rx, input state_t p, input logic u);
        sym_t d;
        d = rx ^ expected_sym(p, u);
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_k3_acs.sv
// Add-compare-select for one trellis state: saturating candidate sums, ties resolved to p0.
module vit_acs_unit #(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            sel_o
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    always_comb begin
        sum0  = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
        sum1  = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
        cand0 = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
        sel_o = (cand1 < cand0);
        pm_o  = sel_o ? cand1 : cand0;
    end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision register-exchange Viterbi decoder for the (7,5) K=3 code; one symbol in,
// one decoded bit out per enabled cycle after TB_LEN symbols.
module viterbi_decoder_k3
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_LEN = 16,
    parameter int unsigned PM_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [1:0] d_in,
    output logic       d_out,
    output logic       valid_o
);

    localparam int unsigned         CNT_W   = $clog2(TB_LEN + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TB_LEN);

    logic [PM_W-1:0]   pm_q   [NUM_STATES];
    logic [PM_W-1:0]   pm_acs [NUM_STATES];
    logic [PM_W-1:0]   pm_d   [NUM_STATES];
    logic [TB_LEN-1:0] path_q [NUM_STATES];
    logic [TB_LEN-1:0] path_d [NUM_STATES];
    logic [NUM_STATES-1:0] sel;
    logic [PM_W-1:0]   pm_min;
    state_t            best;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              d_out_q;
    logic              valid_q;

    // State {u,a} is reached from {a,0} and {a,1}; the decision bit shifted in is u.
    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam state_t P0 = state_t'((g % 2) * 2);
        localparam state_t P1 = state_t'((g % 2) * 2 + 1);
        localparam logic   U  = (g >= 2);

        logic [1:0]        bm0;
        logic [1:0]        bm1;
        logic [TB_LEN-1:0] surv;

        assign bm0 = branch_metric(d_in, P0, U);
        assign bm1 = branch_metric(d_in, P1, U);

        vit_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (pm_acs[g]),
            .sel_o (sel[g])
        );

        assign surv      = sel[g] ? path_q[P1] : path_q[P0];
        assign path_d[g] = {surv[TB_LEN-2:0], U};
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        pm_min = pm_acs[0];
        best   = '0;
        for (int unsigned i = 1; i < NUM_STATES; i++) begin
            if (pm_acs[i] < pm_min) begin
                pm_min = pm_acs[i];
                best   = state_t'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            pm_d[i] = pm_acs[i] - pm_min;
        end
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
                path_q[i] <= '0;
            end
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (enable_i) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= pm_d[i];
                path_q[i] <= path_d[i];
            end
            cnt_q   <= cnt_d;
            d_out_q <= path_d[best][TB_LEN-1];
            valid_q <= (cnt_d == CNT_MAX);
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign d_out   = d_out_q;
    assign valid_o = valid_q;

endmodule
